// File: rtl/wav_sample_buffer.sv
// PCM sample buffer: assembles little-endian 16-bit mono bytes into a FIFO and
// plays one sample per CLK_DIV clocks, emitting silence when the buffer runs dry.
module wav_sample_buffer #(
  parameter int DEPTH_BITS = 9,
  parameter int CLK_DIV    = 1134
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stream_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [15:0]           sample_out,
  output logic [15:0]           sample_out_unsigned,
  output logic                  sample_strobe,
  output logic [DEPTH_BITS:0]   fill_level,
  output logic                  underrun,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int DIV_W = $clog2(CLK_DIV);

  logic [15:0]           mem [DEPTH];
  logic [15:0]           rd_data;
  logic                  sample_valid;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  phase;
  logic [7:0]            lo;
  logic [DIV_W-1:0]      div_cnt;

  logic tick;
  logic accept;
  logic wr_en;
  logic pop;
  logic empty_tick;

  // The only way to reach DEPTH is by writes, so the MSB alone marks "full".
  assign byte_ready = ~fill_level[DEPTH_BITS];
  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign accept     = byte_valid & byte_ready & ~stream_start;
  assign wr_en      = accept & phase;
  assign pop        = tick & ~stream_start & (fill_level != '0);
  assign empty_tick = tick & ~stream_start & (fill_level == '0);

  // After an empty tick the output is forced to silence without touching the RAM.
  assign sample_out          = sample_valid ? rd_data : 16'h0000;
  assign sample_out_unsigned = {~sample_out[15], sample_out[14:0]};

  // NOTE: the storage array and its read register carry no reset so they map onto
  // block RAM; sample_valid masks rd_data until the first real pop.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {byte_data, lo};
    if (pop)   rd_data     <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      sample_strobe <= 1'b0;
      sample_valid  <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      phase         <= 1'b0;
      lo            <= '0;
      underrun      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      div_cnt       <= tick ? '0 : div_cnt + DIV_W'(1);
      sample_strobe <= tick;

      if (pop)             sample_valid <= 1'b1;
      else if (empty_tick) sample_valid <= 1'b0;

      if (stream_start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill_level <= '0;
        phase      <= 1'b0;
        underrun   <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (accept) begin
          phase <= ~phase;
          if (!phase) lo <= byte_data;
        end
        if (wr_en) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
        if (pop)   rd_ptr <= rd_ptr + DEPTH_BITS'(1);
        fill_level <= fill_level + (DEPTH_BITS + 1)'(wr_en) - (DEPTH_BITS + 1)'(pop);
        if (empty_tick)               underrun <= 1'b1;
        if (byte_valid && !byte_ready) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/wav_sample_buffer.md
WAV_SAMPLE_BUFFER -- requirements
Module: wav_sample_buffer

Interface
REQ-001 Parameter DEPTH_BITS, 9, log2 of FIFO depth in 16-bit samples (DEPTH = 512).
REQ-002 Parameter CLK_DIV, 1134, clk cycles per output sample (50 MHz / 44.1 kHz), >= 2.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stream_start  input  1  one-cycle pulse at start of a WAV data chunk; flushes buffer.
REQ-006 byte_valid  input  1  byte_data carries a PCM data-chunk byte this cycle.
REQ-007 byte_data  input  8  PCM byte, little-endian 16-bit signed mono stream.
REQ-008 byte_ready  output  1  buffer accepts a byte this cycle.
REQ-009 sample_out  output  16  current signed PCM sample, held between ticks.
REQ-010 sample_out_unsigned  output  16  sample_out with bit 15 inverted (offset binary, for PWM DAC).
REQ-011 sample_strobe  output  1  one-cycle pulse when sample_out updates.
REQ-012 fill_level  output  DEPTH_BITS+1  number of samples stored.
REQ-013 underrun  output  1  sticky; a tick found the FIFO empty.
REQ-014 overflow  output  1  sticky; byte_valid seen while byte_ready low.

Function
REQ-015 Byte assembly: phase bit, 0 = expecting low byte, 1 = expecting high byte; accepted byte (byte_valid & byte_ready) toggles phase.
REQ-016 Phase 0 accept: latch byte into lo register; no FIFO write.
REQ-017 Phase 1 accept: write {byte_data, lo} into FIFO at write pointer in same cycle; write pointer +1, wraps modulo DEPTH.
REQ-018 byte_ready = (fill_level < DEPTH) registered-free combinational; a pending low byte always has a slot for its high byte since only writes raise fill_level.
REQ-019 byte_valid while byte_ready low: byte dropped, phase unchanged, overflow set.
REQ-020 Tick divider: counter 0..CLK_DIV-1, wraps; tick asserted for one cycle when counter == CLK_DIV-1; free-running, unaffected by stream_start.
REQ-021 On tick with fill_level > 0: pop FIFO head; sample_out and sample_strobe update on the next rising edge (latency 1 cycle from tick).
REQ-022 On tick with FIFO empty: sample_out <= 16'h0000 (silence), sample_strobe pulses, underrun set.
REQ-023 Simultaneous write and pop in one cycle: both performed, fill_level unchanged; pop when empty in same cycle as a write is treated as empty (underrun), written sample retained.
REQ-024 fill_level = write count - pop count; never exceeds DEPTH, never below 0.
REQ-025 stream_start (synchronous): pointers, fill_level, phase, underrun, overflow cleared; sample_out held; takes priority over any write/pop in the same cycle.
REQ-026 FIFO storage is a simple dual-port array inferable as block RAM; read data registered.
REQ-027 No new byte accepted in the stream_start cycle (byte_ready still reported, byte ignored).

Reset
REQ-028 rst high asynchronously forces: pointers 0, fill_level 0, phase 0, lo 0, divider 0, sample_out 0, sample_strobe 0, underrun 0, overflow 0; byte_ready therefore 1.
REQ-029 Reset asserted mid-sample (phase 1) discards pending low byte; first byte after release is a low byte.
REQ-030 FIFO array contents undefined after reset; never read before written.

Verification
REQ-031 Reset, push bytes 34,12,78,56 -> fill_level 2; next ticks give sample_out 16'h1234 then 16'h5678, unsigned 16'h9234 then 16'hD678, one strobe each.
REQ-032 Push 1024 bytes with no ticks -> byte_ready low at fill_level 512; extra byte sets overflow, fill_level stays 512.
REQ-033 Tick with empty FIFO -> sample_out 0, strobe pulse, underrun 1; stream_start clears underrun.
REQ-034 Byte completing a sample in same cycle as tick with fill_level 1 -> fill_level stays 1, popped sample is older one.
REQ-035 Push low byte 8'hAA only, assert rst, then push 11,22 -> stored sample 16'h2211.
REQ-036 Free-run CLK_DIV=1134 -> strobe period exactly 1134 clk cycles across 100 ticks, including across stream_start.
